mmio_router: RTL
================

MMIO_ROUTER -- requirements
Module: mmio_router

Interface
REQ-001 Parameter ADDR_W, 20, CPU address width.
REQ-002 Parameter DATA_W, 16, data width.
REQ-003 Parameter NSLV, 4, number of MMIO slave windows (1..8).
REQ-004 Parameter SLV_BASE, {20'h01000,20'h00008,20'h00004,20'h00000}, packed NSLV*ADDR_W window bases; slave i at bits [i*ADDR_W +: ADDR_W].
REQ-005 Parameter SLV_MASK, {20'hFF000,20'hFFFFC,20'hFFFFE,20'hFFFFC}, packed NSLV*ADDR_W match masks.
REQ-006 Parameter TMO_CYC, 255, WAIT-state timeout in cycles (1..65535).
REQ-007 One clock; reset is asynchronous and active-low.
REQ-008 cpu_clk  in  1  sole clock, all state on rising edge.
REQ-009 rst_in  in  1  asynchronous active-low reset.
REQ-010 m_addr  in  ADDR_W  CPU address, held while request active.
REQ-011 m_wdata  in  DATA_W  CPU write data.
REQ-012 m_rd / m_wr  in  1 each  CPU read / write request levels, held until m_ready.
REQ-013 m_instr  in  1  instruction fetch; forces default port.
REQ-014 m_rdata  out  DATA_W  registered read data; m_ready  out  1  one-cycle completion; m_busy  out  1  high whenever FSM not IDLE.
REQ-015 s_sel  out  NSLV  one-hot slave select; s_rd / s_wr  out  1  one-cycle strobes; s_rd_done  out  NSLV  one-cycle read-consumed pulse.
REQ-016 s_addr  out  ADDR_W  m_addr & ~mask of selected window; s_wdata  out  DATA_W  latched write data.
REQ-017 s_rdata  in  NSLV*DATA_W  slave read data; s_ready  in  NSLV  slave ready (tie high for single-cycle slaves).
REQ-018 d_rd / d_wr  out  1  default (SDRAM) port levels; d_addr  out  ADDR_W; d_rdata  in  DATA_W; d_ready  in  1.
REQ-019 err  out  1  sticky timeout flag; err_addr  out  ADDR_W  address of first timeout; err_clr  in  1  clears err.

Function
REQ-020 Decode: slave i hits when (m_addr & MASK_i) == BASE_i and m_instr=0; lowest matching index wins; no hit or m_instr=1 selects default port.
REQ-021 FSM states IDLE, STROBE, WAIT, DONE, DRAIN.
REQ-022 IDLE: on (m_rd|m_wr) latch addr, wdata, direction, decoded target -> STROBE; m_wr=m_rd=1 treated as write.
REQ-023 STROBE: one cycle; s_rd or s_wr high with s_sel set (slave target) or d_rd/d_wr asserted (default target) -> WAIT.
REQ-024 d_rd/d_wr stay high from STROBE through WAIT, low otherwise; s_sel held STROBE through DONE.
REQ-025 WAIT: on target ready (s_ready[i] or d_ready) capture s_rdata[i]/d_rdata into m_rdata (reads only) -> DONE.
REQ-026 DONE: m_ready=1 for exactly one cycle; for slave reads s_rd_done[i]=1 same cycle -> DRAIN.
REQ-027 DRAIN: wait until m_rd=m_wr=0, then IDLE; a new request is never accepted before drop.
REQ-028 Minimum latency: request sampled at edge N, m_ready high in cycle after edge N+2.
REQ-029 m_rdata unchanged on writes and holds last read value until next read capture.
REQ-030 err_clr and a timeout in the same cycle: err stays set, err_addr updated.

Reset
REQ-031 rst_in low: FSM IDLE, m_rdata=0, m_ready=0, m_busy=0, all strobes/selects/d_rd/d_wr=0, err=0, err_addr=0, timeout counter=0, immediately and asynchronously, including mid-transaction.
REQ-032 Reset release: first request sampled on first rising edge with rst_in high.

Configuration
REQ-033 Macro MMIO_TIMEOUT_EN defined: counter runs in WAIT; reaching TMO_CYC -> DONE with m_rdata all ones (reads), err=1, err_addr captured only if err was 0.
REQ-034 MMIO_TIMEOUT_EN undefined: WAIT unbounded, counter absent, err and err_addr constant 0, err_clr ignored.

Verification
REQ-035 Read 0x00005, s_ready[1]=1, s_rdata[1]=16'h00A5 -> s_rd pulse edge N+1, m_ready cycle N+3, m_rdata=16'h00A5, s_rd_done=4'b0010 once.
REQ-036 Write 0x01234 data 16'hBEEF -> s_sel=4'b1000, s_addr=20'h00234, s_wdata=16'hBEEF, single s_wr pulse, m_rdata unchanged.
REQ-037 Read 0x00002 with m_instr=1 -> d_rd high, s_sel=0; d_ready after 5 cycles with 16'h1234 -> m_rdata=16'h1234.
REQ-038 MMIO_TIMEOUT_EN, TMO_CYC=10, read 0x00008 with s_ready[2]=0 -> m_ready after 10 WAIT cycles, m_rdata=16'hFFFF, err=1, err_addr=20'h00008; err_clr -> err=0.
REQ-039 Hold m_rd high 20 cycles after m_ready -> single transaction, single s_rd_done, FSM DRAIN until drop.
REQ-040 Pull rst_in low during WAIT -> all outputs zero same cycle; post-release read 0x00000 completes normally.

Source files
------------

// File: rtl/mmio_router.sv
// mmio_router: routes CPU MMIO requests to NSLV slave windows or to
// the default (SDRAM) port through a five-state handshake FSM.
//
// Optional feature macro: MMIO_TIMEOUT_EN (WAIT timeout + sticky err).
//
// Ports:
//   cpu_clk, rst_in      clock, async active-low reset
//   m_addr/m_wdata       CPU address / write data
//   m_rd/m_wr/m_instr    CPU request levels, instruction-fetch flag
//   m_rdata/m_ready      registered read data, one-cycle completion
//   m_busy               high whenever the FSM is not idle
//   s_sel/s_rd/s_wr      one-hot slave select, one-cycle strobes
//   s_rd_done            one-cycle read-consumed pulse per slave
//   s_addr/s_wdata       window offset / latched write data
//   s_rdata/s_ready      packed slave read data / slave ready
//   d_rd/d_wr/d_addr     default port levels / address
//   d_rdata/d_ready      default port read data / ready
//   err/err_addr/err_clr sticky timeout flag, first timeout address, clear
module mmio_router #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int NSLV = 4,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE =
    {20'h01000, 20'h00008, 20'h00004, 20'h00000},
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK =
    {20'hFF000, 20'hFFFFC, 20'hFFFFE, 20'hFFFFC},
  parameter int TMO_CYC = 255
) (
  input  logic                   cpu_clk,
  input  logic                   rst_in,
  input  logic [ADDR_W-1:0]      m_addr,
  input  logic [DATA_W-1:0]      m_wdata,
  input  logic                   m_rd,
  input  logic                   m_wr,
  input  logic                   m_instr,
  output logic [DATA_W-1:0]      m_rdata,
  output logic                   m_ready,
  output logic                   m_busy,
  output logic [NSLV-1:0]        s_sel,
  output logic                   s_rd,
  output logic                   s_wr,
  output logic [NSLV-1:0]        s_rd_done,
  output logic [ADDR_W-1:0]      s_addr,
  output logic [DATA_W-1:0]      s_wdata,
  input  logic [NSLV*DATA_W-1:0] s_rdata,
  input  logic [NSLV-1:0]        s_ready,
  output logic                   d_rd,
  output logic                   d_wr,
  output logic [ADDR_W-1:0]      d_addr,
  input  logic [DATA_W-1:0]      d_rdata,
  input  logic                   d_ready,
  output logic                   err,
  output logic [ADDR_W-1:0]      err_addr,
  input  logic                   err_clr
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STROBE = 3'd1,
    WAIT   = 3'd2,
    DONE   = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t state;

  logic          lat_wr;
  logic          lat_slv;
  logic [IW-1:0] lat_idx;

  logic              dec_hit;
  logic [IW-1:0]     dec_idx;
  logic [NSLV-1:0]   dec_oh;
  logic [ADDR_W-1:0] dec_off;

  logic              tgt_ready;
  logic [DATA_W-1:0] tgt_rdata;
  logic              tmo_hit;

  // Descending scan so the lowest matching window is the last writer.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    dec_oh  = '0;
    dec_off = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W])
          == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        dec_hit    = 1'b1;
        dec_idx    = IW'(i);
        dec_oh     = '0;
        dec_oh[i]  = 1'b1;
        dec_off    = m_addr & ~SLV_MASK[i*ADDR_W +: ADDR_W];
      end
    end
    // Instruction fetches always go to the default port.
    if (m_instr) begin
      dec_hit = 1'b0;
      dec_oh  = '0;
      dec_off = '0;
    end
  end

  always_comb begin
    tgt_ready = d_ready;
    tgt_rdata = d_rdata;
    if (lat_slv) begin
      tgt_ready = 1'b0;
      tgt_rdata = '0;
      for (int i = 0; i < NSLV; i++) begin
        if (lat_idx == IW'(i)) begin
          tgt_ready = s_ready[i];
          tgt_rdata = s_rdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

`ifdef MMIO_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign tmo_hit = (state == WAIT) && !tgt_ready &&
                   (tmo_cnt == 16'(TMO_CYC - 1));

  always_ff @(posedge cpu_clk or negedge rst_in) begin
    if (!rst_in) begin
      tmo_cnt  <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      if (state == WAIT && !tgt_ready) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end else begin
        tmo_cnt <= '0;
      end
      // A clear in the same cycle as a timeout re-arms the capture.
      if (tmo_hit) begin
        err <= 1'b1;
        if (!err || err_clr) begin
          err_addr <= d_addr;
        end
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end
`else
  logic unused_clr;

  assign unused_clr = err_clr;
  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
  assign err_addr   = '0;
`endif

  always_ff @(posedge cpu_clk or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      lat_wr    <= 1'b0;
      lat_slv   <= 1'b0;
      lat_idx   <= '0;
      m_rdata   <= '0;
      m_ready   <= 1'b0;
      m_busy    <= 1'b0;
      s_sel     <= '0;
      s_rd      <= 1'b0;
      s_wr      <= 1'b0;
      s_rd_done <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      d_rd      <= 1'b0;
      d_wr      <= 1'b0;
      d_addr    <= '0;
    end else begin
      m_ready   <= 1'b0;
      s_rd      <= 1'b0;
      s_wr      <= 1'b0;
      s_rd_done <= '0;
      unique case (state)
        IDLE: begin
          if (m_rd || m_wr) begin
            state   <= STROBE;
            m_busy  <= 1'b1;
            lat_wr  <= m_wr;
            lat_slv <= dec_hit;
            lat_idx <= dec_idx;
            d_addr  <= m_addr;
            s_wdata <= m_wdata;
            s_addr  <= dec_off;
            if (dec_hit) begin
              s_sel <= dec_oh;
              s_rd  <= !m_wr;
              s_wr  <= m_wr;
            end else begin
              d_rd  <= !m_wr;
              d_wr  <= m_wr;
            end
          end
        end
        STROBE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (tgt_ready || tmo_hit) begin
            state   <= DONE;
            m_ready <= 1'b1;
            d_rd    <= 1'b0;
            d_wr    <= 1'b0;
            if (!lat_wr) begin
              m_rdata <= tgt_ready ? tgt_rdata : '1;
            end
            if (lat_slv && !lat_wr && tgt_ready) begin
              s_rd_done <= s_sel;
            end
          end
        end
        DONE: begin
          state <= DRAIN;
          s_sel <= '0;
        end
        DRAIN: begin
          if (!m_rd && !m_wr) begin
            state  <= IDLE;
            m_busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
